// File: rtl/scratchmem_burst.sv
// Scratchpad RAM slave for the FTA bus: PCI-style config space (cmd, BAR0)
// plus a single-port RAM with a one-beat-per-cycle burst read engine.
module scratchmem_burst #(
   parameter int          DW            = 128,
   parameter int          DEPTH         = 16384,
   parameter int          RD_LAT        = 2,
   parameter string       INIT_FILE     = "rom.mem",
   parameter logic [31:0] BAR0_INIT     = 32'hFFFC0000,
   parameter logic [31:0] BAR0_MASK     = 32'h00FC0000,
   parameter logic [7:0]  CFG_BUS       = 8'd0,
   parameter logic [4:0]  CFG_DEVICE    = 5'd11,
   parameter logic [2:0]  CFG_FUNC      = 3'd0,
   parameter logic [15:0] CFG_VENDOR_ID = 16'h0,
   parameter logic [15:0] CFG_DEVICE_ID = 16'h0,
   parameter int          TIDW          = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cs_config_i,
   input  logic            cs_ram_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [2:0]      cti_i,
   input  logic [5:0]      blen_i,
   input  logic [DW/8-1:0] sel_i,
   input  logic [31:0]     adr_i,
   input  logic [DW-1:0]   dat_i,
   input  logic [TIDW-1:0] tid_i,
   input  logic [3:0]      cid_i,
   output logic            next_o,
   output logic            ack_o,
   output logic [DW-1:0]   dat_o,
   output logic [31:0]     adr_o,
   output logic [TIDW-1:0] tid_o,
   output logic [3:0]      cid_o
);
   localparam int OB = $clog2(DW/8);
   localparam int AW = $clog2(DEPTH);
   localparam int NL = DW/32;
   localparam logic [2:0] CTI_CLASSIC = 3'd0;
   localparam logic [2:0] CTI_ERC     = 3'd7;

   typedef enum logic [1:0] {IDLE, WRITE, RBURST, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              cmd_mem;
   logic [31:0]       bar0, bar0_new, cfg_rdata;
   logic              req, cfg_hit, ram_hit, accept, erc;
   logic [31:0]       req_adr;
   logic [TIDW-1:0]   req_tid;
   logic [3:0]        req_cid;
   logic [DW-1:0]     w_dat;
   logic [DW/8-1:0]   w_sel;
   logic [AW-1:0]     idx;
   logic [5:0]        cnt;
   logic              s1_vld;
   logic [DW-1:0]     s1_dat;
   logic [RD_LAT-1:0] vld_pipe;
   logic [DW-1:0]     rd_pipe  [RD_LAT];
   logic [31:0]       adr_pipe [RD_LAT];
   logic [DW-1:0]     mem      [DEPTH];
   logic              rd_v;

   assign req     = cyc_i & stb_i;
   assign erc     = (cti_i == CTI_ERC);
   assign cfg_hit = cs_config_i & req & (adr_i[27:20] == CFG_BUS) &
                    (adr_i[19:15] == CFG_DEVICE) & (adr_i[14:12] == CFG_FUNC);
   assign ram_hit = ~cfg_hit & cs_ram_i & req & cmd_mem &
                    (((adr_i ^ bar0) & BAR0_MASK) == 32'd0);
   // next_o gating keeps a still-held request from being taken twice
   assign accept  = (state_q == IDLE) & ~next_o & (cfg_hit | ram_hit);
   assign bar0_new = (dat_i[31:0] & BAR0_MASK) | (bar0 & ~BAR0_MASK);
   assign rd_v     = vld_pipe[RD_LAT-1];

   always_comb begin
      cfg_rdata = '0;
      case (adr_i[7:2])
         6'h00:   cfg_rdata = {CFG_DEVICE_ID, CFG_VENDOR_ID};
         6'h01:   cfg_rdata[1] = cmd_mem;
         6'h04:   cfg_rdata = bar0;
         default: cfg_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cmd_mem <= 1'b0;
         bar0    <= BAR0_INIT;
      end else if (accept & cfg_hit & we_i) begin
         case (adr_i[7:2])
            6'h01: if (sel_i[0]) cmd_mem <= dat_i[1];
            6'h04: for (int b = 0; b < 4; b++)
                      if (sel_i[b]) bar0[8*b +: 8] <= bar0_new[8*b +: 8];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept & ram_hit) state_d = we_i ? WRITE : RBURST;
         WRITE:   state_d = IDLE;
         RBURST:  if (cnt == 6'd0) state_d = DRAIN;
         DRAIN:   if (cnt == 6'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cnt: beats still to issue after the current one, then drain cycles left
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_adr <= '0;
         req_tid <= '0;
         req_cid <= '0;
         w_dat   <= '0;
         w_sel   <= '0;
         idx     <= '0;
         cnt     <= '0;
         s1_vld  <= 1'b0;
         s1_dat  <= '0;
      end else begin
         s1_vld <= accept & (cfg_hit ? (~we_i | erc) : (we_i & erc));
         s1_dat <= (accept & cfg_hit & ~we_i) ? {NL{cfg_rdata}} : '0;
         if (accept) begin
            req_adr <= adr_i;
            req_tid <= tid_i;
            req_cid <= cid_i;
            w_dat   <= dat_i;
            w_sel   <= sel_i;
            idx     <= adr_i[AW+OB-1:OB];
            cnt     <= (cti_i == CTI_CLASSIC) ? 6'd0 : blen_i;
         end else if (state_q == RBURST) begin
            idx <= idx + AW'(1);
            cnt <= (cnt == 6'd0) ? 6'(RD_LAT) : cnt - 6'd1;
         end else if (state_q == DRAIN && cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == WRITE)
         for (int b = 0; b < DW/8; b++)
            if (w_sel[b]) mem[idx][8*b +: 8] <= w_dat[8*b +: 8];
      if (state_q == RBURST) begin
         rd_pipe[0]  <= mem[idx];
         adr_pipe[0] <= {req_adr[31:AW+OB], idx, {OB{1'b0}}};
      end
      for (int i = 1; i < RD_LAT; i++) begin
         rd_pipe[i]  <= rd_pipe[i-1];
         adr_pipe[i] <= adr_pipe[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= (state_q == RBURST);
         for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         next_o <= 1'b0;
         ack_o  <= 1'b0;
         dat_o  <= '0;
         adr_o  <= '0;
         tid_o  <= '0;
         cid_o  <= '0;
      end else begin
         next_o <= accept;
         ack_o  <= rd_v | s1_vld;
         dat_o  <= rd_v ? rd_pipe[RD_LAT-1]  : (s1_vld ? s1_dat  : '0);
         adr_o  <= rd_v ? adr_pipe[RD_LAT-1] : (s1_vld ? req_adr : '0);
         tid_o  <= (rd_v | s1_vld) ? req_tid : '0;
         cid_o  <= (rd_v | s1_vld) ? req_cid : '0;
      end
   end
endmodule

// File: tb/tb_scratchmem_burst.sv
// Bench for scratchmem_burst: directed table, multi-cycle corner sequences and
// random traffic checked against a transaction-level memory/config model.
module tb_scratchmem_burst;
   localparam int DW = 64, DEPTH = 64, RD_LAT = 2, TIDW = 8;
   localparam logic [31:0] BINIT = 32'hFFFC0000, BMASK = 32'h00FC0000;
   localparam logic [31:0] CB = 32'h0005_8000, RB = 32'h00FC_0000;

   logic clk = 0, rst = 1;
   logic cs_config = 0, cs_ram = 0, cyc = 0, stb = 0, we = 0;
   logic [2:0] cti = 0;
   logic [5:0] blen = 0;
   logic [7:0] sel = 0;
   logic [31:0] adr = 0;
   logic [63:0] dat = 0;
   logic [TIDW-1:0] tid = 0;
   logic [3:0] cid = 0;
   logic next_o, ack_o;
   logic [63:0] dat_o;
   logic [31:0] adr_o;
   logic [TIDW-1:0] tid_o;
   logic [3:0] cid_o;

   scratchmem_burst #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_FILE(""),
      .BAR0_INIT(BINIT), .BAR0_MASK(BMASK), .CFG_BUS(8'd0), .CFG_DEVICE(5'd11),
      .CFG_FUNC(3'd0), .CFG_VENDOR_ID(16'h1234), .CFG_DEVICE_ID(16'hABCD), .TIDW(TIDW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cs_config_i(cs_config), .cs_ram_i(cs_ram),
      .cyc_i(cyc), .stb_i(stb), .we_i(we), .cti_i(cti), .blen_i(blen), .sel_i(sel),
      .adr_i(adr), .dat_i(dat), .tid_i(tid), .cid_i(cid), .next_o(next_o),
      .ack_o(ack_o), .dat_o(dat_o), .adr_o(adr_o), .tid_o(tid_o), .cid_o(cid_o)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [63:0] ref_mem [DEPTH];
   logic [31:0] m_bar0 = BINIT;
   bit          m_cmd1 = 0;

   typedef struct { int k; bit cd; bit ca; logic [63:0] dat; logic [31:0] adr; } beat_t;
   typedef struct {
      bit cs_cfg; bit cs_ram; bit we; logic [2:0] cti; logic [5:0] blen; logic [7:0] sel;
      logic [31:0] adr; logic [63:0] dat; bit exp_acc; bit chk_lo; logic [31:0] exp_lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t V(bit cf, bit cr, bit w, logic [2:0] c, logic [5:0] bl,
                              logic [7:0] s, logic [31:0] a, logic [63:0] d,
                              bit acc, bit cl, logic [31:0] lo);
      vec_t v;
      v.cs_cfg = cf; v.cs_ram = cr; v.we = w; v.cti = c; v.blen = bl; v.sel = s;
      v.adr = a; v.dat = d; v.exp_acc = acc; v.chk_lo = cl; v.exp_lo = lo;
      return v;
   endfunction

   function automatic logic [31:0] cfg_rd(input logic [5:0] off);
      case (off)
         6'h00:   return 32'hABCD1234;
         6'h01:   return {30'b0, m_cmd1, 1'b0};
         6'h04:   return m_bar0;
         default: return 32'h0;
      endcase
   endfunction

   // One bus transaction: predicts acks from the model, drives, then compares cycle by cycle.
   task automatic txn(input vec_t v, input logic [TIDW-1:0] t, input logic [3:0] c,
                      output bit acc_seen, output logic [31:0] lo);
      beat_t q[$];
      beat_t b;
      bit is_cfg, is_ram, got;
      int kend, nb;
      logic [5:0] ix, w;
      logic [31:0] nbar;
      is_cfg = v.cs_cfg && v.adr[27:20] == 8'd0 && v.adr[19:15] == 5'd11 && v.adr[14:12] == 3'd0;
      is_ram = !is_cfg && v.cs_ram && m_cmd1 && (((v.adr ^ m_bar0) & BMASK) == 32'd0);
      if (is_cfg) begin
         if (!v.we) begin
            b.k = 2; b.cd = 1; b.ca = 0; b.dat = {2{cfg_rd(v.adr[7:2])}}; b.adr = 0;
            q.push_back(b);
         end else begin
            if (v.adr[7:2] == 6'h01 && v.sel[0]) m_cmd1 = v.dat[1];
            if (v.adr[7:2] == 6'h04) begin
               nbar = (v.dat[31:0] & BMASK) | (m_bar0 & ~BMASK);
               for (int i = 0; i < 4; i++) if (v.sel[i]) m_bar0[8*i +: 8] = nbar[8*i +: 8];
            end
            if (v.cti == 3'd7) begin b.k = 2; b.cd = 0; b.ca = 0; b.dat = 0; b.adr = 0; q.push_back(b); end
         end
      end else if (is_ram) begin
         ix = v.adr[8:3];
         if (v.we) begin
            for (int i = 0; i < 8; i++) if (v.sel[i]) ref_mem[ix][8*i +: 8] = v.dat[8*i +: 8];
            if (v.cti == 3'd7) begin b.k = 2; b.cd = 0; b.ca = 0; b.dat = 0; b.adr = 0; q.push_back(b); end
         end else begin
            nb = (v.cti == 3'd0) ? 1 : int'(v.blen) + 1;
            for (int j = 0; j < nb; j++) begin
               w = 6'((int'(ix) + j) % DEPTH);
               b.k = RD_LAT + 2 + j; b.cd = 1; b.ca = 1; b.dat = ref_mem[w];
               b.adr = {v.adr[31:9], w, 3'b000};
               q.push_back(b);
            end
         end
      end
      kend = (is_cfg || is_ram) ? ((q.size() > 0) ? q[q.size()-1].k : 1) : 6;
      @(negedge clk);
      cs_config = v.cs_cfg; cs_ram = v.cs_ram; cyc = 1; stb = 1; we = v.we; cti = v.cti;
      blen = v.blen; sel = v.sel; adr = v.adr; dat = v.dat; tid = t; cid = c;
      got = 0; lo = 32'h0; acc_seen = 0;
      for (int k = 1; k <= kend; k++) begin
         @(negedge clk);
         if (k == 1) acc_seen = next_o;
         chk("next_o", {63'b0, next_o}, {63'b0, (k == 1) && (is_cfg || is_ram)});
         if (k == 1 && (is_cfg || is_ram)) begin cyc = 0; stb = 0; cs_config = 0; cs_ram = 0; end
         if (ack_o) begin
            if (q.size() > 0 && q[0].k == k) begin
               b = q.pop_front();
               if (b.cd) chk("ack_dat", dat_o, b.dat);
               if (b.ca) chk("ack_adr", {32'b0, adr_o}, {32'b0, b.adr});
               chk("ack_tid", {56'b0, tid_o}, {56'b0, t});
               chk("ack_cid", {60'b0, cid_o}, {60'b0, c});
               if (!got) begin lo = dat_o[31:0]; got = 1; end
            end else chk("ack_unexpected", 64'd1, 64'd0);
         end else begin
            if (q.size() > 0 && q[0].k == k) begin chk("ack_missing", 64'd0, 64'd1); void'(q.pop_front()); end
            chk("idle_dat_zero", dat_o, 64'd0);
            chk("idle_tag_zero", {20'b0, adr_o, tid_o, cid_o}, 64'd0);
         end
      end
      cyc = 0; stb = 0; cs_config = 0; cs_ram = 0; we = 0;
   endtask

   vec_t tbl[13];
   vec_t v;
   bit acc;
   logic [31:0] lo;
   logic [31:0] ra;
   int nacks;
   bit ok;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_next",  {63'b0, next_o}, 64'd0);
      chk("rst_ack",   {63'b0, ack_o}, 64'd0);
      chk("rst_dat",   dat_o, 64'd0);
      chk("rst_tags",  {20'b0, adr_o, tid_o, cid_o}, 64'd0);
      @(negedge clk); rst = 0;

      tbl[0]  = V(1,0,0,0,0,8'h0F, CB|32'h10, 64'h0, 1,1, 32'hFFFC0000);
      tbl[1]  = V(1,0,0,0,0,8'h0F, CB|32'h00, 64'h0, 1,1, 32'hABCD1234);
      tbl[2]  = V(0,1,0,0,0,8'hFF, RB|32'h28, 64'h0, 0,0, 32'h0);
      tbl[3]  = V(1,0,1,7,0,8'h0F, CB|32'h04, 64'h2, 1,0, 32'h0);
      tbl[4]  = V(1,0,0,0,0,8'h0F, CB|32'h04, 64'h0, 1,1, 32'h2);
      tbl[5]  = V(1,0,1,7,0,8'h0F, CB|32'h10, 64'h12345678, 1,0, 32'h0);
      tbl[6]  = V(1,0,0,0,0,8'h0F, CB|32'h10, 64'h0, 1,1, 32'hFF340000);
      tbl[7]  = V(0,1,0,0,0,8'hFF, RB|32'h28, 64'h0, 0,0, 32'h0);
      tbl[8]  = V(1,0,1,0,0,8'h0F, CB|32'h10, 64'hFFFC0000, 1,0, 32'h0);
      tbl[9]  = V(1,0,0,0,0,8'h0F, CB|32'h10, 64'h0, 1,1, 32'hFFFC0000);
      tbl[10] = V(1,0,1,7,0,8'h0F, CB|32'h08, 64'hFFFFFFFF, 1,0, 32'h0);
      tbl[11] = V(1,0,0,0,0,8'h0F, CB|32'h08, 64'h0, 1,1, 32'h0);
      tbl[12] = V(1,0,0,0,0,8'h0F, (CB ^ 32'h8000)|32'h10, 64'h0, 0,0, 32'h0);
      for (int i = 0; i < 13; i++) begin
         txn(tbl[i], 8'(i), 4'(i), acc, lo);
         chk("tbl_accept", {63'b0, acc}, {63'b0, tbl[i].exp_acc});
         if (tbl[i].chk_lo) chk("tbl_rdata", {32'b0, lo}, {32'b0, tbl[i].exp_lo});
      end

      for (int w = 0; w < DEPTH; w++)
         txn(V(0,1,1,0,0,8'hFF, RB | (32'(w) << 3), {$urandom, $urandom}, 1,0,0), 8'h0, 4'h0, acc, lo);

      txn(V(0,1,1,7,0,8'h0F, RB|(32'd5<<3), {8{8'hA5}}, 1,0,0), 8'h11, 4'h2, acc, lo);
      txn(V(0,1,0,0,0,8'hFF, RB|(32'd5<<3), 64'h0, 1,0,0), 8'h5A, 4'h9, acc, lo);
      chk("erc_write_then_read_lo", {32'b0, lo}, 64'hA5A5A5A5);
      txn(V(0,1,1,0,0,8'hF0, RB|(32'd7<<3), 64'h0123456789ABCDEF, 1,0,0), 8'h12, 4'h3, acc, lo);
      txn(V(0,1,0,0,0,8'hFF, RB|(32'd7<<3), 64'h0, 1,0,0), 8'h13, 4'h4, acc, lo);
      txn(V(0,1,0,2,3,8'hFF, RB|(32'(DEPTH-2)<<3), 64'h0, 1,0,0), 8'h21, 4'h5, acc, lo);
      txn(V(0,1,0,2,0,8'hFF, RB|(32'd20<<3)|32'h5, 64'h0, 1,0,0), 8'h22, 4'h6, acc, lo);
      txn(V(0,1,0,2,63,8'hFF, 32'hA5FC_0000|(32'd30<<3), 64'h0, 1,0,0), 8'h23, 4'h7, acc, lo);
      txn(V(0,1,0,0,5,8'hFF, RB|(32'd40<<3), 64'h0, 1,0,0), 8'h24, 4'h8, acc, lo);

      // reset in the middle of an 8-beat burst, just as beat 2 is due
      @(negedge clk);
      cs_ram = 1; cyc = 1; stb = 1; we = 0; cti = 3'd2; blen = 6'd7; sel = 8'hFF;
      adr = RB | (32'd10 << 3); tid = 8'h33; cid = 4'h1;
      nacks = 0; ok = 0;
      for (int n = 0; n < 30 && !ok; n++) begin
         @(negedge clk);
         if (next_o) begin cyc = 0; stb = 0; cs_ram = 0; end
         if (ack_o) nacks++;
         if (nacks == 2) ok = 1;
      end
      chk("burst_reached_beat2", {63'b0, ok}, 64'd1);
      cyc = 0; stb = 0; cs_ram = 0;
      rst = 1; #1;
      chk("rst_mid_ack", {63'b0, ack_o}, 64'd0);
      chk("rst_mid_next", {63'b0, next_o}, 64'd0);
      @(negedge clk); rst = 0;
      m_bar0 = BINIT; m_cmd1 = 0;
      txn(V(0,1,0,0,0,8'hFF, RB|(32'd10<<3), 64'h0, 0,0,0), 8'h0, 4'h0, acc, lo);
      txn(V(1,0,1,7,0,8'h0F, CB|32'h04, 64'h2, 1,0,0), 8'h34, 4'h2, acc, lo);
      txn(V(0,1,0,2,7,8'hFF, RB|(32'd10<<3), 64'h0, 1,0,0), 8'h35, 4'h3, acc, lo);

      for (int i = 0; i < 80; i++) begin
         int r, cs;
         r  = $urandom_range(0, 9);
         ra = {8'($urandom), 6'h3F, 9'($urandom), 6'($urandom), 3'($urandom)};
         if (r < 4) begin
            cs = $urandom_range(0, 2);
            v = V(0,1,0, (cs == 0) ? 3'd0 : ((cs == 1) ? 3'd2 : 3'd7), 6'($urandom_range(0, 15)),
                  8'hFF, ra, 64'h0, 0,0,0);
         end else if (r < 7) begin
            v = V(0,1,1, ($urandom_range(0,1) != 0) ? 3'd7 : 3'd0, 6'd0, 8'($urandom), ra,
                  {$urandom, $urandom}, 0,0,0);
         end else if (r < 9) begin
            cs = $urandom_range(0, 3);
            v = V(1,0,0,0,0,8'h0F, {4'($urandom), CB[27:12], 4'($urandom),
                  (cs == 0) ? 6'h00 : ((cs == 1) ? 6'h01 : ((cs == 2) ? 6'h04 : 6'h02)), 2'($urandom)},
                  64'h0, 0,0,0);
         end else begin
            v = V(0,1,0,0,0,8'hFF, ra ^ 32'h0010_0000, 64'h0, 0,0,0);
         end
         txn(v, 8'($urandom), 4'($urandom), acc, lo);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
